// File: rtl/mam_req_ctrl.sv
// MAM request front-end: parses 16-bit debug flits into Wishbone master req/write beats and serialises read beats.
// Optional write acknowledge flit enabled by defining MAM_REQ_CTRL_WRACK_EN.
module mam_req_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLK_I,
  input  logic                    RST_N_I,
  input  logic                    in_valid,
  input  logic [15:0]             in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [15:0]             out_data,
  input  logic                    out_ready,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_rw,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    req_burst,
  output logic [13:0]             req_beats,
  output logic                    write_valid,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH/8-1:0] write_strb,
  input  logic                    write_ready,
  input  logic                    read_valid,
  input  logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_ready
);

  localparam int AW = ADDR_WIDTH / 16;
  localparam int DW = DATA_WIDTH / 16;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    ST_HDR,
    ST_ADDR,
    ST_STRB,
    ST_REQ,
    ST_WDATA,
    ST_WPUSH,
    ST_RDATA,
    ST_RSEND
`ifdef MAM_REQ_CTRL_WRACK_EN
    , ST_WACK
`endif
  } state_t;

  state_t state, next_state;

  logic [13:0]           cnt;
  logic [13:0]           rem;
  logic [13:0]           hdr_beats;
  logic [DATA_WIDTH-1:0] rd_shift;

  // Single accesses always move one word; a zero burst length still moves one.
  always_comb begin
    hdr_beats = in_data[13:0];
    if (!in_data[14] || (in_data[13:0] == 14'd0))
      hdr_beats = 14'd1;
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I)
      state <= ST_HDR;
    else
      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    req_valid   = 1'b0;
    write_valid = 1'b0;
    read_ready  = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ST_HDR: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == 14'd0))
          next_state = (req_rw && !req_burst) ? ST_STRB : ST_REQ;
      end
      ST_STRB: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_REQ;
      end
      ST_REQ: begin
        req_valid = 1'b1;
        if (req_ready) next_state = req_rw ? ST_WDATA : ST_RDATA;
      end
      ST_WDATA: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == 14'd0)) next_state = ST_WPUSH;
      end
      ST_WPUSH: begin
        write_valid = 1'b1;
        if (write_ready) begin
          if (rem == 14'd1)
`ifdef MAM_REQ_CTRL_WRACK_EN
            next_state = ST_WACK;
`else
            next_state = ST_HDR;
`endif
          else
            next_state = ST_WDATA;
        end
      end
      ST_RDATA: begin
        read_ready = 1'b1;
        if (read_valid) next_state = ST_RSEND;
      end
      ST_RSEND: begin
        out_valid = 1'b1;
        if (out_ready && (cnt == 14'd0))
          next_state = (rem == 14'd1) ? ST_HDR : ST_RDATA;
      end
`ifdef MAM_REQ_CTRL_WRACK_EN
      ST_WACK: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_HDR;
      end
`endif
      default: next_state = ST_HDR;
    endcase
    // Handshake outputs must stay quiet while reset is held, even before it takes effect.
    if (!RST_N_I) begin
      in_ready    = 1'b0;
      req_valid   = 1'b0;
      write_valid = 1'b0;
      read_ready  = 1'b0;
      out_valid   = 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      req_rw     <= 1'b0;
      req_burst  <= 1'b0;
      req_beats  <= 14'd0;
      req_addr   <= '0;
      write_data <= '0;
      write_strb <= '1;
      rd_shift   <= '0;
      cnt        <= 14'd0;
      rem        <= 14'd0;
    end else begin
      case (state)
        ST_HDR: if (in_valid) begin
          req_rw     <= in_data[15];
          req_burst  <= in_data[14];
          req_beats  <= hdr_beats;
          write_strb <= '1;
          cnt        <= 14'(AW - 1);
        end
        ST_ADDR: if (in_valid) begin
          req_addr <= (req_addr << 16) | ADDR_WIDTH'(in_data);
          cnt      <= cnt - 14'd1;
        end
        ST_STRB: if (in_valid) write_strb <= in_data[SW-1:0];
        ST_REQ: if (req_ready) begin
          rem <= req_beats;
          cnt <= 14'(DW - 1);
        end
        ST_WDATA: if (in_valid) begin
          write_data <= (write_data << 16) | DATA_WIDTH'(in_data);
          cnt        <= cnt - 14'd1;
        end
        ST_WPUSH: if (write_ready) begin
          rem <= rem - 14'd1;
          cnt <= 14'(DW - 1);
        end
        ST_RDATA: if (read_valid) begin
          rd_shift <= read_data;
          cnt      <= 14'(DW - 1);
        end
        ST_RSEND: if (out_ready) begin
          rd_shift <= rd_shift << 16;
          if (cnt == 14'd0)
            rem <= rem - 14'd1;
          else
            cnt <= cnt - 14'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAM_REQ_CTRL_WRACK_EN
  assign out_data = (state == ST_WACK) ? {2'b10, req_beats} : rd_shift[DATA_WIDTH-1 -: 16];
`else
  assign out_data = rd_shift[DATA_WIDTH-1 -: 16];
`endif

endmodule
